// File: rtl/db4_lattice_synth.sv
// DB4 lattice synthesis: inverse of the two lattice stages, one (g,h) pair
// in per strobe, even/odd samples out at full rate. Ports: clk, reset(n), in_valid, g_in, h_in -> y, y_valid, y_phase, overrun.
`timescale 1ns/1ps
module db4_lattice_synth (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic signed [8:0] g_in,
  input  logic signed [8:0] h_in,
  output logic signed [8:0] y,
  output logic              y_valid,
  output logic              y_phase,
  output logic              overrun
);

  typedef enum logic {IDLE, EMIT_ODD} state_t;

  typedef logic signed [18:0] w_t;

  state_t state, nxt;
  w_t     qd;
  logic signed [8:0] yo_r;

  function automatic w_t scl(input logic signed [8:0] v);
    w_t x;
    x = {{10{v[8]}}, v};
    return (x <<< 7) - (x <<< 2);
  endfunction

  function automatic w_t a1(input w_t v);
    return (v >>> 2) + (v >>> 6) + (v >>> 8);
  endfunction

  function automatic w_t a0(input w_t v);
    return ((v <<< 1) - (v >>> 2)) - ((v >>> 6) + (v >>> 8));
  endfunction

  function automatic logic signed [8:0] sat(input w_t v);
    w_t s;
    s = v >>> 8;
    if (s > 19'sd255)
      return 9'sd255;
    else if (s < -19'sd256)
      return -9'sd256;
    else
      return s[8:0];
  endfunction

  w_t g_s, h_s, p, q, xe, xo;
  logic signed [8:0] ye, yo;

  always_comb begin
    g_s = scl(g_in);
    h_s = scl(h_in);
    p   = g_s + a1(h_s);
    q   = h_s - a1(g_s);
    xe  = p + a0(qd);
    xo  = qd - a0(p);
    ye  = sat(xe);
    yo  = sat(xo);
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (in_valid) nxt = EMIT_ODD;
      EMIT_ODD: nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_phase <= 1'b0;
      overrun <= 1'b0;
      qd      <= '0;
      yo_r    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          y_valid <= in_valid;
          if (in_valid) begin
            y       <= ye;
            y_phase <= 1'b0;
            yo_r    <= yo;
            qd      <= q;
          end
        end
        EMIT_ODD: begin
          // a strobe here is dropped; only the sticky flag records it
          y       <= yo_r;
          y_phase <= 1'b1;
          y_valid <= 1'b1;
          if (in_valid) overrun <= 1'b1;
        end
        default: y_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_db4_lattice_synth.sv
// Self-checking bench for db4_lattice_synth.
// Reference model uses integer floor arithmetic from the lattice equations.
`timescale 1ns/1ps
module tb_db4_lattice_synth;

  logic clk = 0;
  logic reset = 0;
  logic in_valid = 0;
  logic signed [8:0] g_in = 0;
  logic signed [8:0] h_in = 0;
  logic signed [8:0] y;
  logic y_valid, y_phase, overrun;

  int checks = 0;
  int failures = 0;
  int m_qd = 0;

  always #5 clk = ~clk;

  db4_lattice_synth dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .g_in(g_in), .h_in(h_in),
    .y(y), .y_valid(y_valid), .y_phase(y_phase), .overrun(overrun)
  );

  function automatic int fl(input int v, input int k);
    int d;
    d = 1 << k;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int ma1(input int v);
    return fl(v, 2) + fl(v, 6) + fl(v, 8);
  endfunction

  function automatic int ma0(input int v);
    return (2 * v - fl(v, 2)) - (fl(v, 6) + fl(v, 8));
  endfunction

  function automatic int msat(input int v);
    int s;
    s = fl(v, 8);
    if (s > 255) return 255;
    if (s < -256) return -256;
    return s;
  endfunction

  task automatic model(input int g, input int h, output int ye, output int yo);
    int gs, hs, p, q;
    gs = g * 124;
    hs = h * 124;
    p = gs + ma1(hs);
    q = hs - ma1(gs);
    ye = msat(p + ma0(m_qd));
    yo = msat(m_qd - ma0(p));
    m_qd = q;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 0;
    in_valid = 0;
    step();
    step();
    @(negedge clk);
    reset = 1;
    m_qd = 0;
    #1;
  endtask

  task automatic pair(input string nm, input int g, input int h,
                      input int ey, input int oy);
    g_in = 9'(g);
    h_in = 9'(h);
    in_valid = 1;
    step();
    in_valid = 0;
    chk({nm, "_even_y"}, int'(y), ey);
    chk({nm, "_even_v"}, int'(y_valid), 1);
    chk({nm, "_even_ph"}, int'(y_phase), 0);
    step();
    chk({nm, "_odd_y"}, int'(y), oy);
    chk({nm, "_odd_v"}, int'(y_valid), 1);
    chk({nm, "_odd_ph"}, int'(y_phase), 1);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_y", int'(y), 0);
      chk("rst_v", int'(y_valid), 0);
      chk("rst_ph", int'(y_phase), 0);
      chk("rst_ovr", int'(overrun), 0);
    end
  endtask

  task automatic test_impulse();
    int e, o;
    do_reset();
    model(100, 0, e, o);
    chk("imp_model_e", e, 48);
    pair("imp1", 100, 0, 48, -84);
    model(0, 0, e, o);
    pair("imp2", 0, 0, -23, -14);
    step();
    chk("imp_idle_v", int'(y_valid), 0);
    chk("imp_idle_hold", int'(y), -14);
  endtask

  task automatic test_full_scale();
    do_reset();
    pair("fs", 255, 255, 156, -256);
  endtask

  task automatic test_overrun();
    do_reset();
    g_in = 9'sd100;
    h_in = 0;
    in_valid = 1;
    step();
    chk("ovr_even", int'(y), 48);
    g_in = 9'sd50;
    h_in = 9'sd50;
    step();
    chk("ovr_odd", int'(y), -84);
    chk("ovr_odd_ph", int'(y_phase), 1);
    chk("ovr_flag", int'(overrun), 1);
    in_valid = 0;
    pair("ovr_next", 0, 0, -23, -14);
    step();
    step();
    chk("ovr_sticky", int'(overrun), 1);
  endtask

  task automatic test_back_to_back();
    int g, h, e, o;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      g = $signed(8'($urandom));
      h = $signed(8'($urandom));
      model(g, h, e, o);
      pair("b2b", g, h, e, o);
    end
    chk("b2b_ovr", int'(overrun), 0);
  endtask

  task automatic test_reset_mid_pair();
    int e, o;
    do_reset();
    pair("mid_pre", 100, 0, 48, -84);
    g_in = 9'sd100;
    h_in = 0;
    in_valid = 1;
    step();
    in_valid = 0;
    chk("mid_even_v", int'(y_valid), 1);
    reset = 0;
    #1;
    chk("mid_rst_y", int'(y), 0);
    chk("mid_rst_v", int'(y_valid), 0);
    chk("mid_rst_ph", int'(y_phase), 0);
    step();
    @(negedge clk);
    reset = 1;
    m_qd = 0;
    #1;
    model(100, 0, e, o);
    pair("mid_post", 100, 0, e, o);
    chk("mid_post_lit", e, 48);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_full_scale();
    test_overrun();
    test_back_to_back();
    test_reset_mid_pair();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
